// File: rtl/pipe_addsub_lanes_pkg.sv
// Shared op encoding and signed-clamp helpers for the lane add/subtract pipeline.
package addsub_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} addsub_op_e;

  // Clamp value for a w-bit signed result: MIN (1000..0) when sign is set, MAX (0111..1) otherwise.
  function automatic logic [63:0] sat_val(input logic sign, input int w);
    logic [63:0] msb;
    msb = 64'd1 << (w - 1);
    return sign ? msb : (msb - 64'd1);
  endfunction

  function automatic bit seg_div_ok(input int w, input int seg);
    return (seg > 0) && (w >= seg) && ((w % seg) == 0);
  endfunction

endpackage

// File: rtl/pipe_addsub_lanes_rca_seg.sv
// SEG-bit ripple-carry segment; purely combinational, no handshake.
// c_msb_in is the carry into the segment's top bit, used for signed overflow.
module rca_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipe_addsub_lanes.sv
// L-lane add/subtract, one SEG-bit carry segment per stage; latency W/SEG cycles, 1 txn/cycle.
// Backpressure: single global enable (adv); a stalled pipeline holds every stage, bubbles are not squeezed.
module pipe_addsub_lanes
  import addsub_pkg::*;
#(
  parameter int W   = 16,
  parameter int SEG = 4,
  parameter int L   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_op,
  input  logic           in_sat,
  input  logic [L*W-1:0] in_a,
  input  logic [L*W-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [L*W-1:0] out_s,
  output logic [L-1:0]   out_cout,
  output logic [L-1:0]   out_ovf
);

  localparam int NSTG = W / SEG;

  if (!seg_div_ok(W, SEG)) begin : g_bad_seg
    $error("pipe_addsub_lanes: W (%0d) must be a multiple of SEG (%0d)", W, SEG);
  end

  localparam logic [63:0] SMAX64 = sat_val(1'b0, W);
  localparam logic [63:0] SMIN64 = sat_val(1'b1, W);
  localparam logic [W-1:0] SMAX  = SMAX64[W-1:0];
  localparam logic [W-1:0] SMIN  = SMIN64[W-1:0];

  typedef struct packed {
    logic                valid;
    addsub_op_e          op;
    logic                sat;
    logic [L-1:0][W-1:0] a;
    logic [L-1:0][W-1:0] b;
    logic [L-1:0][W-1:0] s;
    logic [L-1:0]        c;
    logic [L-1:0]        ovf;
  } stg_t;

  stg_t stg_q [NSTG];
  stg_t stg_d [NSTG];
  logic adv;

  assign adv      = !stg_q[NSTG-1].valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    stg_t                  src;
    stg_t                  nxt;
    logic [L-1:0][SEG-1:0] seg_s;
    logic [L-1:0]          seg_co;
    logic [L-1:0]          seg_cm;

    if (k == 0) begin : g_src_in
      // Subtract is A + ~B + 1: the +1 enters as the stage-0 carry.
      always_comb begin
        src       = '0;
        src.valid = in_valid;
        src.op    = addsub_op_e'(in_op);
        src.sat   = in_sat;
        src.a     = in_a;
        src.b     = in_b;
        src.c     = {L{in_op}};
      end
    end else begin : g_src_prev
      assign src = stg_q[k-1];
    end

    for (genvar i = 0; i < L; i++) begin : g_lane
      rca_seg #(.SEG(SEG)) u_seg (
        .a        (src.a[i][k*SEG +: SEG]),
        .b        (src.b[i][k*SEG +: SEG] ^ {SEG{src.op == OP_SUB}}),
        .cin      (src.c[i]),
        .s        (seg_s[i]),
        .cout     (seg_co[i]),
        .c_msb_in (seg_cm[i])
      );
    end

    // ovf is recomputed every stage; only the top segment's value survives to the output.
    always_comb begin
      nxt = src;
      for (int i = 0; i < L; i++) begin
        nxt.s[i][k*SEG +: SEG] = seg_s[i];
        nxt.c[i]               = seg_co[i];
        nxt.ovf[i]             = seg_cm[i] ^ seg_co[i];
        if ((k == NSTG - 1) && src.sat && nxt.ovf[i])
          nxt.s[i] = src.a[i][W-1] ? SMIN : SMAX;
      end
    end

    assign stg_d[k] = nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTG; k++) stg_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < NSTG; k++) stg_q[k] <= stg_d[k];
    end
  end

  assign out_valid = stg_q[NSTG-1].valid;
  assign out_s     = stg_q[NSTG-1].s;
  assign out_cout  = stg_q[NSTG-1].c;
  assign out_ovf   = stg_q[NSTG-1].ovf;

endmodule

// File: tb/tb_pipe_addsub_lanes.sv
// Bench for pipe_addsub_lanes: directed W=8/SEG=4/L=2 instance plus a W=32/SEG=8/L=4 random instance.
module tb_pipe_addsub_lanes;

  logic clk;
  logic rst_n;

  logic        v8, r8, op8, sat8, ordy8, ov8;
  logic [15:0] a8, b8, s8;
  logic [1:0]  co8, of8;

  logic         v32, r32, op32, sat32, ordy32, ov32;
  logic [127:0] a32, b32, s32;
  logic [3:0]   co32, of32;

  typedef struct {
    logic [127:0] s;
    logic [3:0]   co;
    logic [3:0]   ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        sat;
    logic [15:0] es;
    logic [1:0]  eco;
    logic [1:0]  eof;
  } txn8_t;

  exp_t q8[$];
  exp_t q32[$];
  int   nchk  = 0;
  int   nfail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_addsub_lanes #(.W(8), .SEG(4), .L(2)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(r8), .in_op(op8), .in_sat(sat8), .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(ordy8), .out_s(s8), .out_cout(co8), .out_ovf(of8)
  );

  pipe_addsub_lanes #(.W(32), .SEG(8), .L(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v32), .in_ready(r32), .in_op(op32), .in_sat(sat32), .in_a(a32), .in_b(b32),
    .out_valid(ov32), .out_ready(ordy32), .out_s(s32), .out_cout(co32), .out_ovf(of32)
  );

  // Reference lane: exact (w+1)-bit sum, overflow from operand/result signs.
  function automatic logic [33:0] ref_lane(input logic [31:0] a, input logic [31:0] b,
                                           input logic op, input logic sat, input int w);
    logic [63:0] mask, aa, bb, full, sum;
    logic        co, ov, sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = op ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    full = aa + bb + {63'd0, op};
    sum  = full & mask;
    co   = full[w];
    sa   = a[w-1];
    sb   = b[w-1];
    ss   = sum[w-1];
    ov   = op ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    if (sat && ov) sum = sa ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
    return {co, ov, sum[31:0]};
  endfunction

  function automatic exp_t model(input logic [127:0] a, input logic [127:0] b,
                                 input logic op, input logic sat, input int w, input int l);
    exp_t        e;
    logic [33:0] r;
    e.s   = '0;
    e.co  = '0;
    e.ovf = '0;
    for (int i = 0; i < l; i++) begin
      r = ref_lane(32'(a >> (i * w)), 32'(b >> (i * w)), op, sat, w);
      e.s      = e.s | (128'(r[31:0]) << (i * w));
      e.co[i]  = r[33];
      e.ovf[i] = r[32];
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    v8 = 0; op8 = 0; sat8 = 0; a8 = '0; b8 = '0; ordy8 = 1;
    v32 = 0; op32 = 0; sat32 = 0; a32 = '0; b32 = '0; ordy32 = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    nchk++; if (ov8 !== 1'b0) begin nfail++; $display("FAIL reset_out_valid: got %b expected 0", ov8); end
    nchk++; if (s8 !== 16'h0) begin nfail++; $display("FAIL reset_out_s: got %h expected 0000", s8); end
    nchk++; if ({co8, of8} !== 4'b0) begin nfail++; $display("FAIL reset_cout_ovf: got %b expected 0000", {co8, of8}); end
    nchk++; if (r8 !== 1'b1) begin nfail++; $display("FAIL reset_in_ready: got %b expected 1", r8); end
    nchk++; if ({ov32, co32, of32} !== 9'b0) begin nfail++; $display("FAIL reset_wide: got %b expected 0", {ov32, co32, of32}); end
    nchk++; if (r32 !== 1'b1) begin nfail++; $display("FAIL reset_wide_in_ready: got %b expected 1", r32); end
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    ordy8 = 1; v8 = 1; op8 = 0; sat8 = 0; a8 = 16'h0135; b8 = 16'h024A;
    @(negedge clk);
    nchk++; if (r8 !== 1'b1) begin nfail++; $display("FAIL lat_in_ready: got %b expected 1", r8); end
    @(posedge clk); #1;
    v8 = 0;
    @(negedge clk);
    nchk++; if (ov8 !== 1'b0) begin nfail++; $display("FAIL lat_early: out_valid %b one cycle after handshake, expected 0", ov8); end
    @(negedge clk);
    nchk++; if (ov8 !== 1'b1) begin nfail++; $display("FAIL lat_valid: out_valid %b two cycles after handshake, expected 1", ov8); end
    nchk++; if (s8 !== 16'h037F) begin nfail++; $display("FAIL lat_sum: got %h expected 037F", s8); end
    nchk++; if ({co8, of8} !== 4'b0000) begin nfail++; $display("FAIL lat_flags: got cout=%b ovf=%b expected 00 00", co8, of8); end
  endtask

  task automatic test_directed();
    txn8_t tv[8];
    exp_t  e;
    int    sent = 0, got = 0, cyc = 0;
    tv[0] = {16'h2010, 16'h1020, 1'b1, 1'b0, 16'h10F0, 2'b10, 2'b00};
    tv[1] = {16'h0F70, 16'h0120, 1'b0, 1'b1, 16'h107F, 2'b00, 2'b01};
    tv[2] = {16'h0F70, 16'h0120, 1'b0, 1'b0, 16'h1090, 2'b00, 2'b01};
    tv[3] = {16'h8080, 16'h7F01, 1'b1, 1'b1, 16'h8080, 2'b11, 2'b11};
    tv[4] = {16'h8080, 16'h7F01, 1'b1, 1'b0, 16'h017F, 2'b11, 2'b11};
    tv[5] = {16'hFF0F, 16'h0101, 1'b0, 1'b0, 16'h0010, 2'b10, 2'b00};
    tv[6] = {16'hC010, 16'hC020, 1'b0, 1'b1, 16'h8030, 2'b10, 2'b00};
    tv[7] = {16'h007F, 16'h80FF, 1'b1, 1'b1, 16'h7F7F, 2'b00, 2'b11};
    @(posedge clk); #1;
    ordy8 = 1;
    while (got < 8 && cyc < 100) begin
      v8 = (sent < 8);
      if (sent < 8) begin a8 = tv[sent].a; b8 = tv[sent].b; op8 = tv[sent].op; sat8 = tv[sent].sat; end
      @(negedge clk);
      if (ov8 && ordy8) begin
        e = q8.pop_front();
        nchk++;
        if ({s8, co8, of8} !== {e.s[15:0], e.co[1:0], e.ovf[1:0]}) begin
          nfail++;
          $display("FAIL dir[%0d]: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                   got, s8, co8, of8, e.s[15:0], e.co[1:0], e.ovf[1:0]);
        end
        got++;
      end
      if (v8 && r8) begin
        e.s = 128'(tv[sent].es); e.co = 4'(tv[sent].eco); e.ovf = 4'(tv[sent].eof);
        q8.push_back(e);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    v8 = 0;
    nchk++; if (got != 8) begin nfail++; $display("FAIL dir_timeout: received %0d expected 8", got); end
  endtask

  task automatic test_backpressure();
    txn8_t       tv[10];
    exp_t        e;
    int          sent = 0, got = 0, cyc = 0;
    bit          stalled = 0;
    logic [20:0] held = '0;
    for (int i = 0; i < 10; i++) tv[i] = {16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 20'd0};
    @(posedge clk); #1;
    while (got < 10 && cyc < 300) begin
      ordy8 = (cyc >= 4 && cyc < 9) ? 1'b0 : 1'($urandom_range(0, 1));
      v8 = (sent < 10);
      if (sent < 10) begin a8 = tv[sent].a; b8 = tv[sent].b; op8 = tv[sent].op; sat8 = tv[sent].sat; end
      @(negedge clk);
      nchk++;
      if (r8 !== (!ov8 || ordy8)) begin nfail++; $display("FAIL bp_in_ready: got %b expected %b", r8, !ov8 || ordy8); end
      if (stalled) begin
        nchk++;
        if ({ov8, s8, co8, of8} !== held) begin nfail++; $display("FAIL bp_hold: got %h expected %h", {ov8, s8, co8, of8}, held); end
      end
      stalled = ov8 && !ordy8;
      held    = {ov8, s8, co8, of8};
      if (ov8 && ordy8) begin
        if (q8.size() == 0) begin
          nchk++; nfail++; $display("FAIL bp_extra: unexpected output s=%h", s8);
        end else begin
          e = q8.pop_front();
          nchk++;
          if ({s8, co8, of8} !== {e.s[15:0], e.co[1:0], e.ovf[1:0]}) begin
            nfail++;
            $display("FAIL bp_data[%0d]: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                     got, s8, co8, of8, e.s[15:0], e.co[1:0], e.ovf[1:0]);
          end
          got++;
        end
      end
      if (v8 && r8) begin
        q8.push_back(model(128'(a8), 128'(b8), op8, sat8, 8, 2));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    v8 = 0;
    ordy8 = 1;
    nchk++; if (got != 10 || q8.size() != 0) begin nfail++; $display("FAIL bp_count: received %0d pending %0d expected 10 and 0", got, q8.size()); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    ordy8 = 0; v8 = 1; op8 = 0; sat8 = 0; a8 = 16'h1111; b8 = 16'h2222;
    @(posedge clk); #1;
    a8 = 16'h3333;
    @(posedge clk); #1;
    v8 = 0;
    nchk++; if (ov8 !== 1'b1) begin nfail++; $display("FAIL rst_inflight: out_valid %b expected 1 before reset", ov8); end
    #2 rst_n = 1'b0;
    #1;
    nchk++; if (ov8 !== 1'b0) begin nfail++; $display("FAIL rst_async_valid: got %b expected 0", ov8); end
    nchk++; if ({s8, co8, of8} !== 20'h0) begin nfail++; $display("FAIL rst_async_data: got %h expected 0", {s8, co8, of8}); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    ordy8 = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nchk++; if (ov8 !== 1'b0) begin nfail++; $display("FAIL rst_stale[%0d]: out_valid %b expected 0", i, ov8); end
    end
  endtask

  task automatic test_wide();
    localparam int N = 10000;
    exp_t e;
    int   sent = 0, got = 0, cyc = 0;
    bit   hold = 0;
    @(posedge clk); #1;
    while (got < N && cyc < 40000) begin
      ordy32 = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        v32   = (sent < N) && ($urandom_range(0, 9) != 0);
        a32   = {$urandom(), $urandom(), $urandom(), $urandom()};
        b32   = {$urandom(), $urandom(), $urandom(), $urandom()};
        op32  = 1'($urandom);
        sat32 = 1'($urandom);
      end
      @(negedge clk);
      nchk++;
      if (r32 !== (!ov32 || ordy32)) begin nfail++; $display("FAIL wide_in_ready: got %b expected %b", r32, !ov32 || ordy32); end
      if (ov32 && ordy32) begin
        if (q32.size() == 0) begin
          nchk++; nfail++; $display("FAIL wide_extra: unexpected output s=%h", s32);
        end else begin
          e = q32.pop_front();
          nchk++;
          if ({s32, co32, of32} !== {e.s, e.co, e.ovf}) begin
            nfail++;
            $display("FAIL wide_data[%0d]: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                     got, s32, co32, of32, e.s, e.co, e.ovf);
          end
          got++;
        end
      end
      if (v32 && r32) begin
        q32.push_back(model(a32, b32, op32, sat32, 32, 4));
        sent++;
      end
      hold = v32 && !r32;
      @(posedge clk); #1;
      cyc++;
    end
    v32 = 0;
    nchk++; if (got != N || q32.size() != 0) begin nfail++; $display("FAIL wide_count: received %0d pending %0d expected %0d and 0", got, q32.size(), N); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
